// File: rtl/cache_pkg.sv
// Shared constants and FSM encoding for the MEM-stage data cache.
// Default geometry: 4-word lines, 8 sets, 25-bit tags.
package cache_pkg;

    localparam int BYTE_ADDR_LEN     = 2;
    localparam int DEF_LINE_ADDR_LEN = 2;
    localparam int DEF_SET_ADDR_LEN  = 3;
    localparam int DEF_TAG_ADDR_LEN  = 32 - BYTE_ADDR_LEN - DEF_LINE_ADDR_LEN - DEF_SET_ADDR_LEN;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE      = 2'd0;
    localparam fsm_state_t ST_WRITEBACK = 2'd1;
    localparam fsm_state_t ST_FILL      = 2'd2;
    localparam fsm_state_t ST_INSTALL   = 2'd3;

    function automatic int line_width(input int line_addr_len);
        return 32 << line_addr_len;
    endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Valid/dirty/tag/data storage for a direct-mapped cache.
// Combinational read port, byte-enabled word write and whole-line install.
module dcache_line_array
    import cache_pkg::*;
#(
    parameter int LINE_ADDR_LEN = DEF_LINE_ADDR_LEN,
    parameter int SET_ADDR_LEN  = DEF_SET_ADDR_LEN,
    parameter int TAG_ADDR_LEN  = DEF_TAG_ADDR_LEN
)(
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [SET_ADDR_LEN-1:0]             rd_set_i,
    output logic                                rd_valid_o,
    output logic                                rd_dirty_o,
    output logic [TAG_ADDR_LEN-1:0]             rd_tag_o,
    output logic [(32<<LINE_ADDR_LEN)-1:0]      rd_line_o,
    input  logic                                wr_en_i,
    input  logic [SET_ADDR_LEN-1:0]             wr_set_i,
    input  logic [LINE_ADDR_LEN-1:0]            wr_word_i,
    input  logic [31:0]                         wr_data_i,
    input  logic [3:0]                          wr_be_i,
    input  logic                                inst_en_i,
    input  logic [SET_ADDR_LEN-1:0]             inst_set_i,
    input  logic [TAG_ADDR_LEN-1:0]             inst_tag_i,
    input  logic [(32<<LINE_ADDR_LEN)-1:0]      inst_line_i
);

    localparam int NUM_SETS   = 1 << SET_ADDR_LEN;
    localparam int LINE_WIDTH = line_width(LINE_ADDR_LEN);

    logic [NUM_SETS-1:0]     valid_q;
    logic [NUM_SETS-1:0]     dirty_q;
    logic [TAG_ADDR_LEN-1:0] tag_q  [NUM_SETS];
    logic [LINE_WIDTH-1:0]   data_q [NUM_SETS];

    assign rd_valid_o = valid_q[rd_set_i];
    assign rd_dirty_o = dirty_q[rd_set_i];
    assign rd_tag_o   = tag_q[rd_set_i];
    assign rd_line_o  = data_q[rd_set_i];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (inst_en_i) begin
            valid_q[inst_set_i] <= 1'b1;
            dirty_q[inst_set_i] <= 1'b0;
        end else if (wr_en_i) begin
            dirty_q[wr_set_i] <= 1'b1;
        end
    end

    // Tag and data contents are meaningless until valid is set, so no reset here.
    always_ff @(posedge clk) begin
        if (inst_en_i) begin
            tag_q[inst_set_i]  <= inst_tag_i;
            data_q[inst_set_i] <= inst_line_i;
        end else if (wr_en_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be_i[b]) begin
                    data_q[wr_set_i][(int'(wr_word_i) * 32) + (b * 8) +: 8] <= wr_data_i[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dcache_miss_ctrl.sv
// Direct-mapped write-back/write-allocate D-cache for the MEM stage:
// same-cycle hits, and a writeback/fill/install FSM that stalls the pipeline on a miss.
module dcache_miss_ctrl
    import cache_pkg::*;
#(
    parameter int  LINE_ADDR_LEN = DEF_LINE_ADDR_LEN,
    parameter int  SET_ADDR_LEN  = DEF_SET_ADDR_LEN,
    localparam int TAG_ADDR_LEN  = 32 - BYTE_ADDR_LEN - LINE_ADDR_LEN - SET_ADDR_LEN
)(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            RdReq,
    input  logic                            WrReq,
    input  logic [31:0]                     Addr,
    input  logic [31:0]                     WrData,
    input  logic [3:0]                      WrBe,
    output logic [31:0]                     RdData,
    output logic                            DCacheMiss,
    output logic                            MemRdReq,
    output logic                            MemWrReq,
    output logic [31:0]                     MemAddr,
    output logic [(32<<LINE_ADDR_LEN)-1:0]  MemWrLine,
    input  logic [(32<<LINE_ADDR_LEN)-1:0]  MemRdLine,
    input  logic                            MemGnt,
    output logic [31:0]                     HitCount,
    output logic [31:0]                     MissCount
);

    localparam int LINE_WIDTH = line_width(LINE_ADDR_LEN);
    localparam int WORDS      = 1 << LINE_ADDR_LEN;
    localparam int OFFS_LEN   = BYTE_ADDR_LEN + LINE_ADDR_LEN;

    fsm_state_t              state_q, state_d;
    logic [TAG_ADDR_LEN-1:0] miss_tag_q, miss_tag_d;
    logic [SET_ADDR_LEN-1:0] miss_set_q, miss_set_d;
    logic [LINE_WIDTH-1:0]   fill_line_q, fill_line_d;
    logic [31:0]             hit_count_q, hit_count_d;
    logic [31:0]             miss_count_q, miss_count_d;

    logic                     req, in_idle, hit, miss_start;
    logic [TAG_ADDR_LEN-1:0]  req_tag;
    logic [SET_ADDR_LEN-1:0]  req_set, arr_set;
    logic [LINE_ADDR_LEN-1:0] req_word;
    logic                     arr_valid, arr_dirty;
    logic [TAG_ADDR_LEN-1:0]  arr_tag;
    logic [LINE_WIDTH-1:0]    arr_line;
    logic [31:0]              line_words [WORDS];
    logic                     unused_byte_bits;

    assign req_tag          = Addr[31 -: TAG_ADDR_LEN];
    assign req_set          = Addr[OFFS_LEN +: SET_ADDR_LEN];
    assign req_word         = Addr[BYTE_ADDR_LEN +: LINE_ADDR_LEN];
    assign unused_byte_bits = ^Addr[BYTE_ADDR_LEN-1:0];

    assign req     = RdReq || WrReq;
    assign in_idle = (state_q == ST_IDLE);
    // Outside IDLE the array is addressed by the latched miss set, so the victim stays visible.
    assign arr_set = in_idle ? req_set : miss_set_q;

    dcache_line_array #(
        .LINE_ADDR_LEN (LINE_ADDR_LEN),
        .SET_ADDR_LEN  (SET_ADDR_LEN),
        .TAG_ADDR_LEN  (TAG_ADDR_LEN)
    ) u_array (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_set_i    (arr_set),
        .rd_valid_o  (arr_valid),
        .rd_dirty_o  (arr_dirty),
        .rd_tag_o    (arr_tag),
        .rd_line_o   (arr_line),
        .wr_en_i     (hit && WrReq),
        .wr_set_i    (req_set),
        .wr_word_i   (req_word),
        .wr_data_i   (WrData),
        .wr_be_i     (WrBe),
        .inst_en_i   (state_q == ST_INSTALL),
        .inst_set_i  (miss_set_q),
        .inst_tag_i  (miss_tag_q),
        .inst_line_i (fill_line_q)
    );

    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
        assign line_words[gi] = arr_line[gi*32 +: 32];
    end

    assign hit        = req && in_idle && arr_valid && (arr_tag == req_tag);
    assign miss_start = req && in_idle && !hit;

    // Simultaneous read+write is handled as a store, so no load data is returned for it.
    assign RdData     = (rst_n && hit && !WrReq) ? line_words[req_word] : 32'd0;
    assign DCacheMiss = rst_n && ((req && !hit) || !in_idle);

    assign MemWrReq  = (state_q == ST_WRITEBACK);
    assign MemRdReq  = (state_q == ST_FILL);
    assign MemWrLine = MemWrReq ? arr_line : '0;

    always_comb begin
        MemAddr = 32'd0;
        if (MemWrReq) begin
            MemAddr = {arr_tag, miss_set_q, {OFFS_LEN{1'b0}}};
        end else if (MemRdReq) begin
            MemAddr = {miss_tag_q, miss_set_q, {OFFS_LEN{1'b0}}};
        end
    end

    always_comb begin
        state_d     = state_q;
        miss_tag_d  = miss_tag_q;
        miss_set_d  = miss_set_q;
        fill_line_d = fill_line_q;
        case (state_q)
            ST_IDLE: begin
                if (miss_start) begin
                    miss_tag_d = req_tag;
                    miss_set_d = req_set;
                    state_d    = (arr_valid && arr_dirty) ? ST_WRITEBACK : ST_FILL;
                end
            end
            ST_WRITEBACK: begin
                if (MemGnt) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (MemGnt) begin
                    fill_line_d = MemRdLine;
                    state_d     = ST_INSTALL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign hit_count_d  = hit_count_q + (hit ? 32'd1 : 32'd0);
    assign miss_count_d = miss_count_q + (miss_start ? 32'd1 : 32'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            miss_tag_q   <= '0;
            miss_set_q   <= '0;
            fill_line_q  <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            miss_tag_q   <= miss_tag_d;
            miss_set_q   <= miss_set_d;
            fill_line_q  <= fill_line_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign HitCount  = hit_count_q;
    assign MissCount = miss_count_q;

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Bench for dcache_miss_ctrl: directed vector table, reset/spurious-grant sequences,
// and random traffic checked against a flat-memory reference of the cache.
module tb_dcache_miss_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         RdReq = 1'b0, WrReq = 1'b0;
    logic [31:0]  Addr = 32'd0, WrData = 32'd0;
    logic [3:0]   WrBe = 4'd0;
    logic [31:0]  RdData, MemAddr, HitCount, MissCount;
    logic         DCacheMiss, MemRdReq, MemWrReq;
    logic [127:0] MemWrLine;
    logic [127:0] MemRdLine = '0;
    logic         MemGnt = 1'b0;

    dcache_miss_ctrl dut (
        .clk(clk), .rst_n(rst_n), .RdReq(RdReq), .WrReq(WrReq), .Addr(Addr),
        .WrData(WrData), .WrBe(WrBe), .RdData(RdData), .DCacheMiss(DCacheMiss),
        .MemRdReq(MemRdReq), .MemWrReq(MemWrReq), .MemAddr(MemAddr),
        .MemWrLine(MemWrLine), .MemRdLine(MemRdLine), .MemGnt(MemGnt),
        .HitCount(HitCount), .MissCount(MissCount)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Backing memory (what the responder serves) and architectural memory (reference view).
    bit [31:0] mem  [bit [31:0]];
    bit [31:0] gold [bit [31:0]];

    function automatic bit [31:0] init_word(input bit [31:0] a);
        return {a[15:0], 16'hA5C3};
    endfunction
    function automatic bit [31:0] mem_rd(input bit [31:0] a);
        return mem.exists(a) ? mem[a] : init_word(a);
    endfunction
    function automatic bit [31:0] gold_rd(input bit [31:0] a);
        return gold.exists(a) ? gold[a] : init_word(a);
    endfunction

    // Memory responder: grants after 'lat' request cycles; 'spur_tok' bumps inject a stray grant.
    int lat = 5;
    int cnt = 0;
    int spur_tok = 0;
    int spur_seen = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            cnt = 0;
            MemGnt = 1'b0;
        end else if (MemGnt) begin
            MemGnt = 1'b0;
            cnt = 0;
        end else if (spur_tok != spur_seen) begin
            spur_seen = spur_tok;
            MemRdLine = {4{32'hDEAD_BEEF}};
            MemGnt = 1'b1;
        end else if (MemRdReq || MemWrReq) begin
            cnt++;
            if (cnt >= lat) begin
                MemGnt = 1'b1;
                for (int w = 0; w < 4; w++) begin
                    if (MemRdReq) MemRdLine[32*w +: 32] = mem_rd(MemAddr + 32'(4*w));
                    else mem[MemAddr + 32'(4*w)] = MemWrLine[32*w +: 32];
                end
            end
        end else begin
            cnt = 0;
        end
    end

    // Reference cache state: which line each set holds and whether it is dirty.
    bit        mv [8];
    bit        md [8];
    bit [24:0] mt [8];
    int        exp_hits = 0, exp_misses = 0;

    function automatic void model_reset();
        for (int s = 0; s < 8; s++) begin
            mv[s] = 1'b0;
            md[s] = 1'b0;
        end
        exp_hits = 0;
        exp_misses = 0;
        gold = mem;
    endfunction

    task automatic access(input bit rd, input bit wr, input bit [31:0] a, input bit [31:0] d,
                          input bit [3:0] be, output bit was_miss, output bit had_wb,
                          output logic [31:0] rdata);
        bit [2:0]     set = a[6:4];
        bit [24:0]    tag = a[31:7];
        bit [31:0]    wa = {a[31:2], 2'b00};
        int           exp_n = 0;
        bit           exp_wr [2];
        bit [31:0]    exp_addr [2];
        bit [127:0]   exp_line = '0;
        bit           model_miss;
        bit [31:0]    exp_rdata;
        bit [31:0]    w;
        int           n_ops = 0;
        bit           op_wr [4];
        logic [31:0]  op_addr [4];
        logic [127:0] op_line [4];
        bit           prev_rd = 0, prev_wr = 0, both = 0, done = 0;
        int           miss_cycles = 0;

        model_miss = !(mv[set] && mt[set] == tag);
        if (model_miss) begin
            if (mv[set] && md[set]) begin
                exp_wr[0] = 1'b1;
                exp_addr[0] = {mt[set], set, 4'b0};
                for (int k = 0; k < 4; k++) exp_line[32*k +: 32] = gold_rd(exp_addr[0] + 32'(4*k));
                exp_n = 1;
            end
            exp_wr[exp_n] = 1'b0;
            exp_addr[exp_n] = {tag, set, 4'b0};
            exp_n++;
            exp_misses++;
            mv[set] = 1'b1;
            mt[set] = tag;
            md[set] = 1'b0;
        end
        exp_hits++;
        exp_rdata = gold_rd(wa);
        if (wr) begin
            md[set] = 1'b1;
            w = gold_rd(wa);
            for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
            gold[wa] = w;
        end

        @(negedge clk);
        RdReq = rd; WrReq = wr; Addr = a; WrData = d; WrBe = be;
        for (int c = 0; c < 300; c++) begin
            #1;
            if (!DCacheMiss) begin
                done = 1;
                break;
            end
            miss_cycles++;
            if (MemRdReq && MemWrReq) both = 1;
            if (n_ops < 4 && ((MemWrReq && !prev_wr) || (MemRdReq && !prev_rd))) begin
                op_wr[n_ops] = MemWrReq;
                op_addr[n_ops] = MemAddr;
                op_line[n_ops] = MemWrLine;
                n_ops++;
            end
            prev_rd = MemRdReq;
            prev_wr = MemWrReq;
            @(negedge clk);
        end
        if (!done) check("access_timeout", 1'b1, 1'b0);
        rdata = RdData;
        @(negedge clk);
        RdReq = 1'b0; WrReq = 1'b0;
        #1;
        was_miss = (miss_cycles > 0);
        had_wb = (n_ops > 0) && op_wr[0];
        check("miss_vs_model", was_miss, model_miss);
        check("rd_wr_together", both, 1'b0);
        check("mem_op_count", n_ops, exp_n);
        for (int k = 0; k < exp_n && k < n_ops; k++) begin
            check("mem_op_kind", op_wr[k], exp_wr[k]);
            check("mem_op_addr", op_addr[k], exp_addr[k]);
            if (exp_wr[k]) check("wb_line", op_line[k], exp_line);
        end
        if (rd && !wr) check("rddata_vs_model", rdata, exp_rdata);
        check("hit_count", HitCount, exp_hits);
        check("miss_count", MissCount, exp_misses);
    endtask

    typedef struct {
        bit        rd;
        bit        wr;
        bit [31:0] addr;
        bit [31:0] data;
        bit [3:0]  be;
        bit        exp_miss;
        bit        exp_wb;
        bit [31:0] exp_rdata;
    } vec_t;

    vec_t        vecs [5];
    bit          vm, vw;
    logic [31:0] vr;
    bit          ok;

    initial begin
        vecs[0] = '{1, 0, 32'h10, 32'h0,        4'h0,    1, 0, 32'h11};
        vecs[1] = '{1, 0, 32'h18, 32'h0,        4'h0,    0, 0, 32'h33};
        vecs[2] = '{0, 1, 32'h14, 32'hAABBCCDD, 4'b0011, 0, 0, 32'h0};
        vecs[3] = '{1, 0, 32'h14, 32'h0,        4'h0,    0, 0, 32'h0000CCDD};
        vecs[4] = '{1, 0, 32'h90, 32'h0,        4'h0,    1, 1, 32'h0090A5C3};
        mem[32'h10] = 32'h11; mem[32'h14] = 32'h22; mem[32'h18] = 32'h33; mem[32'h1C] = 32'h44;
        model_reset();

        // Reset state, with a load already pending on the bus.
        RdReq = 1'b1; Addr = 32'h10;
        repeat (3) @(negedge clk);
        #1;
        check("rst_dcachemiss", DCacheMiss, 1'b0);
        check("rst_memrdreq", MemRdReq, 1'b0);
        check("rst_memwrreq", MemWrReq, 1'b0);
        check("rst_rddata", RdData, 32'd0);
        check("rst_hitcount", HitCount, 32'd0);
        check("rst_misscount", MissCount, 32'd0);
        RdReq = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_dcachemiss", DCacheMiss, 1'b0);

        for (int i = 0; i < 5; i++) begin
            access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].be, vm, vw, vr);
            check($sformatf("vec%0d_miss", i), vm, vecs[i].exp_miss);
            check($sformatf("vec%0d_wb", i), vw, vecs[i].exp_wb);
            if (vecs[i].rd) check($sformatf("vec%0d_rddata", i), vr, vecs[i].exp_rdata);
            $display("vec%0d addr=%08h miss=%0b wb=%0b rdata=%08h", i, vecs[i].addr, vm, vw, vr);
        end

        // Stray grant while idle must not disturb state or contents.
        @(negedge clk);
        spur_tok++;
        repeat (3) @(negedge clk);
        #1;
        check("spur_state", {MemRdReq, MemWrReq, DCacheMiss}, 3'b000);
        check("spur_hitcount", HitCount, exp_hits);
        check("spur_misscount", MissCount, exp_misses);
        access(1, 0, 32'h90, 0, 0, vm, vw, vr);
        check("spur_reread_miss", vm, 1'b0);
        check("spur_reread_data", vr, 32'h0090A5C3);
        $display("spurious grant: reread 0x90 miss=%0b rdata=%08h", vm, vr);

        // Reset in the middle of a fill.
        lat = 20;
        @(negedge clk);
        RdReq = 1'b1; Addr = 32'h110;
        ok = 0;
        for (int c = 0; c < 50; c++) begin
            #1;
            if (MemRdReq) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        check("midfill_reached", ok, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midfill_memrdreq", MemRdReq, 1'b0);
        check("midfill_dcachemiss", DCacheMiss, 1'b0);
        check("midfill_hitcount", HitCount, 32'd0);
        check("midfill_misscount", MissCount, 32'd0);
        RdReq = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        lat = 3;
        access(1, 0, 32'h90, 0, 0, vm, vw, vr);
        check("postrst_miss", vm, 1'b1);
        check("postrst_wb", vw, 1'b0);
        check("postrst_data", vr, 32'h0090A5C3);
        $display("reset mid-fill: reread 0x90 miss=%0b wb=%0b rdata=%08h", vm, vw, vr);

        // Random traffic over 4 tags competing for 8 sets.
        for (int i = 0; i < 300; i++) begin
            bit [31:0] a;
            bit        is_wr;
            bit [3:0]  be;
            a = {23'd0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'b00};
            is_wr = 1'($urandom_range(0, 1));
            be = 4'($urandom_range(1, 15));
            lat = $urandom_range(1, 4);
            access(!is_wr, is_wr, a, $urandom, be, vm, vw, vr);
            $display("rand%0d %s addr=%08h miss=%0b wb=%0b rdata=%08h", i, is_wr ? "WR" : "RD", a, vm, vw, vr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
